fifo_entrada: RTL and testbench
===============================

# fifo_entrada

Per-lane input FIFO that buffers WORD_SIZE-bit words in front of the round-robin arbiter. Four instances, one per lane, feed the arbiter's fifo_data_in0..3, fifos_empty[3:0] and fifos_almost_full[3:0]. Each instance receives the arbiter's matching fifos_pop bit. It is a first-word-fall-through buffer with configurable almost-full/almost-empty thresholds and sticky overflow/underflow detection.

## Interface
Parameters:
- WORD_SIZE, 12, data word width
- ADDR_SIZE, 3, pointer width; depth = 2**ADDR_SIZE (8)
- ALMOST_FULL_LVL, 6, almost_full asserted when count >= this value
- ALMOST_EMPTY_LVL, 2, almost_empty asserted when count <= this value

Ports:
- clk  input  1  single clock, all state updates on its rising edge
- reset  input  1  synchronous, active-high; clears all state on the rising clk edge where it is 1
- push  input  1  write request; data_in is stored at the next edge if accepted
- data_in  input  WORD_SIZE  write data
- pop  input  1  read request; the head word is removed at the next edge if accepted
- data_out  output  WORD_SIZE  head word (FWFT); 0 when empty
- empty  output  1  count == 0
- full  output  1  count == 2**ADDR_SIZE
- almost_full  output  1  count >= ALMOST_FULL_LVL
- almost_empty  output  1  count <= ALMOST_EMPTY_LVL
- error  output  1  sticky; set on overflow or underflow attempt
- count  output  ADDR_SIZE+1  current occupancy, 0..2**ADDR_SIZE

## Operation
- Storage: 2**ADDR_SIZE-entry register array, write pointer wr_ptr, read pointer rd_ptr (ADDR_SIZE bits each), occupancy counter count (ADDR_SIZE+1 bits).
- Pointers wrap modulo depth (7 -> 0). Full and empty are distinguished by count, not by pointer compare.
- Accepted push: mem[wr_ptr] <= data_in, wr_ptr+1.
- Accepted pop: rd_ptr+1.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Push when full with no pop: dropped; mem, wr_ptr and count are unchanged; error <= 1.
- Push and pop when full: both accepted; count stays at depth.
- Pop when empty: ignored; error <= 1.
- Push and pop when empty: the push is accepted, the pop is an underflow (error <= 1), count becomes 1.
- error clears only on reset.
- data_out = empty ? 0 : mem[rd_ptr], combinational from registered state. The arbiter samples it in the same cycle it raises pop.
- Flags are decoded from registered count. They are never combinational from push/pop.

## Timing
- Reset values: wr_ptr=rd_ptr=0, count=0, mem cleared to 0, data_out=0, empty=1, full=0, almost_full=0, almost_empty=1, error=0.
- reset has priority over push/pop in the same cycle. Asserting reset mid-stream discards all contents at that edge.
- Write-to-read latency is 1 cycle: a word pushed at edge N is on data_out and empty=0 after edge N.
- Pop at edge N presents the next word (or 0 and empty=1) after edge N.
- Flag latency is 1 edge after the push/pop that changes count.
- Sustained push+pop every cycle at any occupancy gives a throughput of 1 word/cycle.

## Structure
- Shared package fifo_pkg:
  - default WORD_SIZE=12, ADDR_SIZE=3, ALMOST_FULL_LVL=6, ALMOST_EMPTY_LVL=2
  - lane count NUM_FIFOS=4, shared with the arbiter
- One sub-module, fifo_mem: a simple dual-port register file with synchronous write (we, waddr, wdata, cleared on reset) and asynchronous read (raddr -> rdata).
- fifo_entrada holds the pointers, counter, flags and error logic.

## Test plan
- Reset, then push 0xACC, 0xACF, 0xECD on consecutive cycles:
  - after the first edge, data_out=0xACC and empty=0.
  - count=3, almost_empty=0 after the third push.
  - pop ×3 yields 0xACC, 0xACF, 0xECD in order, then empty=1 and data_out=0.
- Push 8 words without pop:
  - almost_full rises after the 6th edge; full after the 8th.
  - a 9th push leaves count=8 and sets error=1. Contents are unchanged, verified by draining 8 words in order.
- At count=8, push 0x111 and pop in the same cycle: count stays 8, the head advances, and 0x111 is read out last.
- Reset, then pop with empty=1: count stays 0, error=1. A simultaneous push+pop when empty gives count=1 and data_out equal to the pushed word.
- Push/pop to wrap the pointers twice (20 words streamed at occupancy 3): the output order matches the input order and count stays 3 throughout.
- Assert reset while count=5 and push=1: after the edge count=0, empty=1, almost_empty=1, error=0, and the pushed word is not stored.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared parameters for the per-lane input FIFOs and the round-robin arbiter they feed.
package fifo_pkg;

    localparam int DEF_WORD_SIZE        = 12;
    localparam int DEF_ADDR_SIZE        = 3;
    localparam int DEF_ALMOST_FULL_LVL  = 6;
    localparam int DEF_ALMOST_EMPTY_LVL = 2;
    localparam int NUM_FIFOS            = 4;

    // Occupancy-derived status, decoded from the registered count only.
    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/fifo_mem.sv
// Dual-port register file: synchronous write cleared by reset, asynchronous read.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WORD_SIZE,
    parameter int ADDR  = DEF_ADDR_SIZE
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_we,
    input  logic [ADDR-1:0]  i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [ADDR-1:0]  i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR;

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_entrada.sv
// First-word-fall-through lane FIFO in front of the round-robin arbiter, with
// count-based full/empty, threshold flags and a sticky overflow/underflow error.
module fifo_entrada
    import fifo_pkg::*;
#(
    parameter int WORD_SIZE        = DEF_WORD_SIZE,
    parameter int ADDR_SIZE        = DEF_ADDR_SIZE,
    parameter int ALMOST_FULL_LVL  = DEF_ALMOST_FULL_LVL,
    parameter int ALMOST_EMPTY_LVL = DEF_ALMOST_EMPTY_LVL
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 pop,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 error,
    output logic [ADDR_SIZE:0]   count
);

    localparam int                 DEPTH     = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] CNT_DEPTH = (ADDR_SIZE+1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] CNT_AF    = (ADDR_SIZE+1)'(ALMOST_FULL_LVL);
    localparam logic [ADDR_SIZE:0] CNT_AE    = (ADDR_SIZE+1)'(ALMOST_EMPTY_LVL);
    localparam logic [ADDR_SIZE:0] CNT_ONE   = (ADDR_SIZE+1)'(1);
    localparam logic [ADDR_SIZE-1:0] PTR_ONE = ADDR_SIZE'(1);

    logic [ADDR_SIZE-1:0] r_wr_ptr;
    logic [ADDR_SIZE-1:0] r_rd_ptr;
    logic [ADDR_SIZE:0]   r_count;
    logic                 r_error;

    logic [ADDR_SIZE:0]   w_count_nxt;
    logic [WORD_SIZE-1:0] w_rdata;
    logic                 w_push_ok;
    logic                 w_pop_ok;
    logic                 w_overflow;
    logic                 w_underflow;
    fifo_flags_t          w_flags;

    // Handshake: push and pop are requests sampled on the rising edge. A pop is
    // accepted whenever the FIFO holds a word; a push is accepted when not full,
    // or when full and a pop is accepted in the same cycle. data_out is valid
    // whenever empty is 0 and is the word a pop in that cycle removes.
    assign w_pop_ok    = pop && !w_flags.empty;
    assign w_push_ok   = push && (!w_flags.full || pop);
    assign w_overflow  = push && w_flags.full && !pop;
    assign w_underflow = pop && w_flags.empty;

    assign w_flags.empty        = (r_count == '0);
    assign w_flags.full         = (r_count == CNT_DEPTH);
    assign w_flags.almost_full  = (r_count >= CNT_AF);
    assign w_flags.almost_empty = (r_count <= CNT_AE);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
            if (w_overflow || w_underflow) begin
                r_error <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .WIDTH (WORD_SIZE),
        .ADDR  (ADDR_SIZE)
    ) u_mem (
        .i_clk   (clk),
        .i_reset (reset),
        .i_we    (w_push_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // The arbiter samples data_out in the cycle it raises pop, so it must not lag.
    assign data_out     = w_flags.empty ? '0 : w_rdata;
    assign empty        = w_flags.empty;
    assign full         = w_flags.full;
    assign almost_full  = w_flags.almost_full;
    assign almost_empty = w_flags.almost_empty;
    assign error        = r_error;
    assign count        = r_count;

endmodule

// File: tb/tb_fifo_entrada.sv
// Scoreboard bench for fifo_entrada: queue-based reference model plus a negedge monitor.
module tb_fifo_entrada;

    localparam int W     = 12;
    localparam int A     = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic         clk     = 1'b0;
    logic         reset   = 1'b1;
    logic         push    = 1'b0;
    logic         pop     = 1'b0;
    logic [W-1:0] data_in = '0;

    logic [W-1:0] data_out;
    logic         empty;
    logic         full;
    logic         almost_full;
    logic         almost_empty;
    logic         error;
    logic [A:0]   count;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_q[$];
    bit           model_err = 1'b0;
    bit           mon_en    = 1'b0;
    int           n_vec     = 0;
    int           n_err     = 0;

    always #5 clk = ~clk;

    fifo_entrada #(
        .WORD_SIZE        (W),
        .ADDR_SIZE        (A),
        .ALMOST_FULL_LVL  (AF),
        .ALMOST_EMPTY_LVL (AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error),
        .count        (count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a plain queue of stored words plus the sticky error bit.
    task automatic model_step(input bit r, input bit p, input logic [W-1:0] d, input bit q);
        bit was_full;
        bit was_empty;
        if (r) begin
            model_q.delete();
            exp_q.delete();
            model_err = 1'b0;
            return;
        end
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        if (p && was_full && !q) model_err = 1'b1;
        if (q && was_empty) model_err = 1'b1;
        if (q && !was_empty) void'(model_q.pop_front());
        if (p && (!was_full || q)) begin
            model_q.push_back(d);
            exp_q.push_back(d);
        end
    endtask

    task automatic cycle(input bit r, input bit p, input logic [W-1:0] d, input bit q);
        reset   = r;
        push    = p;
        data_in = d;
        pop     = q;
        @(posedge clk);
        #1;
        model_step(r, p, d, q);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b1);
    endtask

    // Monitor: flags and head checked against the model every cycle; each popped
    // word is matched against the scoreboard queue.
    always @(negedge clk) begin
        int           sz;
        logic [W-1:0] e;
        if (mon_en) begin
            sz = model_q.size();
            check("count", 32'(count), 32'(sz));
            check("empty", 32'(empty), 32'(sz == 0));
            check("full", 32'(full), 32'(sz == DEPTH));
            check("almost_full", 32'(almost_full), 32'(sz >= AF));
            check("almost_empty", 32'(almost_empty), 32'(sz <= AE));
            check("error", 32'(error), 32'(model_err));
            check("head", 32'(data_out), (sz != 0) ? 32'(model_q[0]) : 32'h0);
            if (pop && !reset && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pop_data", 32'(data_out), 32'(e));
            end
        end
    end

    initial begin
        do_reset();
        mon_en = 1'b1;
        do_reset();
        check("rst_count", 32'(count), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        check("rst_ae", 32'(almost_empty), 32'h1);
        check("rst_af", 32'(almost_full), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_data", 32'(data_out), 32'h0);

        // Basic FWFT ordering
        cycle(1'b0, 1'b1, 12'hACC, 1'b0);
        check("fwft_data", 32'(data_out), 32'hACC);
        check("fwft_empty", 32'(empty), 32'h0);
        cycle(1'b0, 1'b1, 12'hACF, 1'b0);
        cycle(1'b0, 1'b1, 12'hECD, 1'b0);
        check("three_count", 32'(count), 32'h3);
        check("three_ae", 32'(almost_empty), 32'h0);
        drain(3);
        check("drained_empty", 32'(empty), 32'h1);
        check("drained_data", 32'(data_out), 32'h0);

        // Fill to full, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, W'(12'h200 + i), 1'b0);
            if (i == AF - 2) check("af_before", 32'(almost_full), 32'h0);
            if (i == AF - 1) check("af_at_6", 32'(almost_full), 32'h1);
            if (i == DEPTH - 2) check("full_before", 32'(full), 32'h0);
        end
        check("full_at_8", 32'(full), 32'h1);
        cycle(1'b0, 1'b1, 12'hBAD, 1'b0);
        check("ovf_count", 32'(count), 32'h8);
        check("ovf_error", 32'(error), 32'h1);
        drain(DEPTH);

        // Push+pop while full
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, W'(12'h300 + i), 1'b0);
        cycle(1'b0, 1'b1, 12'h111, 1'b1);
        check("full_pp_count", 32'(count), 32'h8);
        check("full_pp_head", 32'(data_out), 32'h301);
        drain(DEPTH);

        // Underflow, then push+pop while empty
        do_reset();
        cycle(1'b0, 1'b0, '0, 1'b1);
        check("unf_count", 32'(count), 32'h0);
        check("unf_error", 32'(error), 32'h1);
        cycle(1'b0, 1'b1, 12'h5A5, 1'b1);
        check("empty_pp_count", 32'(count), 32'h1);
        check("empty_pp_data", 32'(data_out), 32'h5A5);
        drain(1);

        // Stream 20 words at occupancy 3 so both pointers wrap twice
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, W'(12'h400 + i), 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, W'(12'h500 + i), 1'b1);
        check("stream_count", 32'(count), 32'h3);
        drain(3);

        // Reset wins over a push in the same cycle
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, W'(12'h600 + i), 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b1, 12'h605, 1'b0);
        check("pre_rst_count", 32'(count), 32'h5);
        cycle(1'b1, 1'b1, 12'h777, 1'b0);
        check("rstpush_count", 32'(count), 32'h0);
        check("rstpush_empty", 32'(empty), 32'h1);
        check("rstpush_ae", 32'(almost_empty), 32'h1);
        check("rstpush_error", 32'(error), 32'h0);
        check("rstpush_data", 32'(data_out), 32'h0);

        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35),
                  W'($urandom_range(0, (1 << W) - 1)),
                  $urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
        end
        drain(DEPTH + 1);
        idle(2);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
